// File: rtl/pong_pkg.sv
// Shared constants and state type for the Pong game logic.
// Geometry defaults, step sizes and the centre/serve position helper.
package pong_pkg;

   localparam int DEF_SCREEN_W   = 640;
   localparam int DEF_SCREEN_H   = 480;
   localparam int DEF_BALL_SIZE  = 8;
   localparam int DEF_PADDLE_X   = 16;
   localparam int DEF_PADDLE_W   = 8;
   localparam int DEF_PADDLE_H   = 64;
   localparam int DEF_BALL_STEP  = 2;
   localparam int DEF_PADDLE_STEP = 4;

   localparam int DEF_CENTER_X   = (DEF_SCREEN_W - DEF_BALL_SIZE) / 2;
   localparam int DEF_CENTER_Y   = (DEF_SCREEN_H - DEF_BALL_SIZE) / 2;

   typedef enum logic {
      PLAY  = 1'b0,
      SERVE = 1'b1
   } game_state_t;

   // Top-left coordinate that centres an object of length obj_len in span.
   function automatic int centre_pos(input int span, input int obj_len);
      return (span - obj_len) / 2;
   endfunction

endpackage

// File: rtl/game_state_module_paddle_ctrl.sv
// Paddle vertical position register: saturating step from the joystick,
// advanced only on frame ticks.
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int SCREEN_H    = DEF_SCREEN_H,
   parameter int PADDLE_H    = DEF_PADDLE_H,
   parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       update_screen,
   input  logic       joystick_up,
   input  logic       joystick_down,
   output logic [9:0] paddle_y
);

   localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - PADDLE_H);
   localparam logic [10:0] STEP   = 11'(PADDLE_STEP);
   localparam logic [9:0]  Y_INIT = 10'(centre_pos(SCREEN_H, PADDLE_H));

   logic [9:0]  paddle_y_reg;
   logic [9:0]  paddle_y_next;
   logic [10:0] y_ext;

   assign y_ext = {1'b0, paddle_y_reg};

   always_comb begin
      paddle_y_next = paddle_y_reg;
      if (update_screen) begin
         if (joystick_up && !joystick_down) begin
            if (y_ext <= STEP)
               paddle_y_next = '0;
            else
               paddle_y_next = 10'(y_ext - STEP);
         end else if (joystick_down && !joystick_up) begin
            if (y_ext + STEP >= Y_MAX)
               paddle_y_next = Y_MAX[9:0];
            else
               paddle_y_next = 10'(y_ext + STEP);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         paddle_y_reg <= Y_INIT;
      else
         paddle_y_reg <= paddle_y_next;
   end

   assign paddle_y = paddle_y_reg;

endmodule

// File: rtl/game_state_module.sv
// Pong game state: ball motion with wall/paddle bounces and a PLAY/SERVE
// state machine, stepped once per frame tick.
module game_state_module
   import pong_pkg::*;
#(
   parameter int SCREEN_W    = DEF_SCREEN_W,
   parameter int SCREEN_H    = DEF_SCREEN_H,
   parameter int BALL_SIZE   = DEF_BALL_SIZE,
   parameter int PADDLE_X    = DEF_PADDLE_X,
   parameter int PADDLE_W    = DEF_PADDLE_W,
   parameter int PADDLE_H    = DEF_PADDLE_H,
   parameter int BALL_STEP   = DEF_BALL_STEP,
   parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       update_screen,
   input  logic       joystick_up,
   input  logic       joystick_down,
   input  logic       arcade_button_pressed,
   output logic [9:0] ball_top,
   output logic [9:0] ball_left,
   output logic [9:0] paddleX,
   output logic [9:0] paddleY
);

   localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
   localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - BALL_SIZE);
   localparam logic [10:0] STEP     = 11'(BALL_STEP);
   localparam logic [10:0] PAD_EDGE = 11'(PADDLE_X + PADDLE_W);
   localparam logic [10:0] SIZE     = 11'(BALL_SIZE);
   localparam logic [10:0] PAD_H    = 11'(PADDLE_H);
   localparam logic [9:0]  CENTER_X = 10'(centre_pos(SCREEN_W, BALL_SIZE));
   localparam logic [9:0]  CENTER_Y = 10'(centre_pos(SCREEN_H, BALL_SIZE));

   game_state_t state_reg, state_next;
   logic [9:0]  ball_x_reg, ball_x_next;
   logic [9:0]  ball_y_reg, ball_y_next;
   logic        dx_right_reg, dx_right_next;
   logic        dy_down_reg, dy_down_next;

   logic [9:0]  paddle_y;
   logic [10:0] x_ext, y_ext, pad_ext;
   logic        overlap;

   paddle_ctrl #(
      .SCREEN_H    (SCREEN_H),
      .PADDLE_H    (PADDLE_H),
      .PADDLE_STEP (PADDLE_STEP)
   ) u_paddle (
      .clock         (clock),
      .reset         (reset),
      .update_screen (update_screen),
      .joystick_up   (joystick_up),
      .joystick_down (joystick_down),
      .paddle_y      (paddle_y)
   );

   assign x_ext   = {1'b0, ball_x_reg};
   assign y_ext   = {1'b0, ball_y_reg};
   assign pad_ext = {1'b0, paddle_y};
   // Overlap uses the paddle position from before this tick's joystick move.
   assign overlap = (y_ext + SIZE > pad_ext) && (y_ext < pad_ext + PAD_H);

   always_comb begin
      state_next    = state_reg;
      ball_x_next   = ball_x_reg;
      ball_y_next   = ball_y_reg;
      dx_right_next = dx_right_reg;
      dy_down_next  = dy_down_reg;
      if (update_screen) begin
         case (state_reg)
            PLAY: begin
               if (dy_down_reg) begin
                  if (y_ext + STEP >= Y_MAX) begin
                     ball_y_next  = Y_MAX[9:0];
                     dy_down_next = 1'b0;
                  end else begin
                     ball_y_next = 10'(y_ext + STEP);
                  end
               end else begin
                  if (y_ext <= STEP) begin
                     ball_y_next  = '0;
                     dy_down_next = 1'b1;
                  end else begin
                     ball_y_next = 10'(y_ext - STEP);
                  end
               end

               if (dx_right_reg) begin
                  if (x_ext + STEP >= X_MAX) begin
                     ball_x_next   = X_MAX[9:0];
                     dx_right_next = 1'b0;
                  end else begin
                     ball_x_next = 10'(x_ext + STEP);
                  end
               end else if ((x_ext <= PAD_EDGE + STEP) && overlap) begin
                  ball_x_next   = PAD_EDGE[9:0];
                  dx_right_next = 1'b1;
               end else if (x_ext <= STEP) begin
                  // Missed: the serve reset overrides this tick's vertical move.
                  state_next    = SERVE;
                  ball_x_next   = CENTER_X;
                  ball_y_next   = CENTER_Y;
                  dx_right_next = 1'b1;
                  dy_down_next  = 1'b1;
               end else begin
                  ball_x_next = 10'(x_ext - STEP);
               end
            end
            SERVE: begin
               ball_x_next   = CENTER_X;
               ball_y_next   = CENTER_Y;
               dx_right_next = 1'b1;
               dy_down_next  = 1'b1;
               if (arcade_button_pressed)
                  state_next = PLAY;
            end
            default: state_next = PLAY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= PLAY;
         ball_x_reg   <= CENTER_X;
         ball_y_reg   <= CENTER_Y;
         dx_right_reg <= 1'b1;
         dy_down_reg  <= 1'b1;
      end else begin
         state_reg    <= state_next;
         ball_x_reg   <= ball_x_next;
         ball_y_reg   <= ball_y_next;
         dx_right_reg <= dx_right_next;
         dy_down_reg  <= dy_down_next;
      end
   end

   assign ball_top  = ball_y_reg;
   assign ball_left = ball_x_reg;
   assign paddleX   = 10'(PADDLE_X);
   assign paddleY   = paddle_y;

endmodule

// File: tb/tb_game_state_module.sv
// Directed bench for game_state_module: reset, free run, wall bounces,
// paddle saturation, paddle hit, miss/serve and mid-play reset.
module tb_game_state_module;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       update_screen = 1'b0;
   logic       joystick_up = 1'b0;
   logic       joystick_down = 1'b0;
   logic       arcade_button_pressed = 1'b0;
   logic [9:0] ball_top, ball_left, paddleX, paddleY;

   int check_count = 0;
   int pass_count  = 0;

   game_state_module dut (
      .clock                 (clock),
      .reset                 (reset),
      .update_screen         (update_screen),
      .joystick_up           (joystick_up),
      .joystick_down         (joystick_down),
      .arcade_button_pressed (arcade_button_pressed),
      .ball_top              (ball_top),
      .ball_left             (ball_left),
      .paddleX               (paddleX),
      .paddleY               (paddleY)
   );

   always #5 clock = ~clock;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      update_screen = 1'b0;
      joystick_up = 1'b0;
      joystick_down = 1'b0;
      arcade_button_pressed = 1'b0;
   endtask

   task automatic run(input int n);
      update_screen = 1'b1;
      repeat (n) @(negedge clock);
      update_screen = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      check_count++; if (ball_top !== 10'd236) $display("FAIL reset_top: got %0d expected 236", ball_top); else pass_count++;
      check_count++; if (ball_left !== 10'd316) $display("FAIL reset_left: got %0d expected 316", ball_left); else pass_count++;
      check_count++; if (paddleY !== 10'd208) $display("FAIL reset_paddleY: got %0d expected 208", paddleY); else pass_count++;
      check_count++; if (paddleX !== 10'd16) $display("FAIL reset_paddleX: got %0d expected 16", paddleX); else pass_count++;
      $display("test_reset: top=%0d left=%0d py=%0d px=%0d", ball_top, ball_left, paddleY, paddleX);
   endtask

   task automatic test_free_run();
      do_reset();
      run(10);
      check_count++; if (ball_top !== 10'd256) $display("FAIL run10_top: got %0d expected 256", ball_top); else pass_count++;
      check_count++; if (ball_left !== 10'd336) $display("FAIL run10_left: got %0d expected 336", ball_left); else pass_count++;
      // No tick: joystick and button must have no effect.
      joystick_down = 1'b1;
      arcade_button_pressed = 1'b1;
      repeat (5) @(negedge clock);
      joystick_down = 1'b0;
      arcade_button_pressed = 1'b0;
      check_count++; if (ball_top !== 10'd256) $display("FAIL hold_top: got %0d expected 256", ball_top); else pass_count++;
      check_count++; if (ball_left !== 10'd336) $display("FAIL hold_left: got %0d expected 336", ball_left); else pass_count++;
      check_count++; if (paddleY !== 10'd208) $display("FAIL hold_paddleY: got %0d expected 208", paddleY); else pass_count++;
      $display("test_free_run: top=%0d left=%0d py=%0d", ball_top, ball_left, paddleY);
   endtask

   task automatic test_wall_bounce();
      do_reset();
      run(118);
      check_count++; if (ball_top !== 10'd472) $display("FAIL bottom_wall: got %0d expected 472", ball_top); else pass_count++;
      run(1);
      check_count++; if (ball_top !== 10'd470) $display("FAIL bottom_rebound: got %0d expected 470", ball_top); else pass_count++;
      do_reset();
      run(158);
      check_count++; if (ball_left !== 10'd632) $display("FAIL right_wall: got %0d expected 632", ball_left); else pass_count++;
      run(1);
      check_count++; if (ball_left !== 10'd630) $display("FAIL right_rebound: got %0d expected 630", ball_left); else pass_count++;
      $display("test_wall_bounce: top=%0d left=%0d", ball_top, ball_left);
   endtask

   task automatic test_paddle();
      do_reset();
      joystick_up = 1'b1;
      run(51);
      check_count++; if (paddleY !== 10'd4) $display("FAIL paddle_up51: got %0d expected 4", paddleY); else pass_count++;
      run(1);
      check_count++; if (paddleY !== 10'd0) $display("FAIL paddle_up52: got %0d expected 0", paddleY); else pass_count++;
      run(3);
      check_count++; if (paddleY !== 10'd0) $display("FAIL paddle_top_sat: got %0d expected 0", paddleY); else pass_count++;
      joystick_up = 1'b0;
      joystick_down = 1'b1;
      run(103);
      check_count++; if (paddleY !== 10'd412) $display("FAIL paddle_down103: got %0d expected 412", paddleY); else pass_count++;
      run(3);
      check_count++; if (paddleY !== 10'd416) $display("FAIL paddle_bottom_sat: got %0d expected 416", paddleY); else pass_count++;
      joystick_up = 1'b1;
      run(5);
      check_count++; if (paddleY !== 10'd416) $display("FAIL paddle_both_hold: got %0d expected 416", paddleY); else pass_count++;
      joystick_up = 1'b0;
      joystick_down = 1'b0;
      $display("test_paddle: py=%0d", paddleY);
   endtask

   task automatic test_paddle_hit();
      do_reset();
      run(354);
      check_count++; if (ball_top !== 10'd0) $display("FAIL top_wall: got %0d expected 0", ball_top); else pass_count++;
      run(107);
      check_count++; if (ball_left !== 10'd26) $display("FAIL hit_approach_left: got %0d expected 26", ball_left); else pass_count++;
      check_count++; if (ball_top !== 10'd214) $display("FAIL hit_approach_top: got %0d expected 214", ball_top); else pass_count++;
      run(1);
      check_count++; if (ball_left !== 10'd24) $display("FAIL hit_left: got %0d expected 24", ball_left); else pass_count++;
      run(1);
      check_count++; if (ball_left !== 10'd26) $display("FAIL hit_rebound: got %0d expected 26", ball_left); else pass_count++;
      $display("test_paddle_hit: top=%0d left=%0d", ball_top, ball_left);
   endtask

   task automatic test_serve();
      do_reset();
      joystick_up = 1'b1;
      run(473);
      check_count++; if (ball_left !== 10'd2) $display("FAIL miss_approach: got %0d expected 2", ball_left); else pass_count++;
      run(1);
      check_count++; if (ball_top !== 10'd236 || ball_left !== 10'd316)
         $display("FAIL miss_centre: got (%0d,%0d) expected (236,316)", ball_top, ball_left); else pass_count++;
      joystick_up = 1'b0;
      run(20);
      check_count++; if (ball_top !== 10'd236 || ball_left !== 10'd316)
         $display("FAIL serve_frozen: got (%0d,%0d) expected (236,316)", ball_top, ball_left); else pass_count++;
      arcade_button_pressed = 1'b1;
      run(1);
      arcade_button_pressed = 1'b0;
      check_count++; if (ball_top !== 10'd236 || ball_left !== 10'd316)
         $display("FAIL serve_button_tick: got (%0d,%0d) expected (236,316)", ball_top, ball_left); else pass_count++;
      run(1);
      check_count++; if (ball_top !== 10'd238 || ball_left !== 10'd318)
         $display("FAIL serve_first_move: got (%0d,%0d) expected (238,318)", ball_top, ball_left); else pass_count++;
      $display("test_serve: top=%0d left=%0d", ball_top, ball_left);
   endtask

   task automatic test_reset_mid_play();
      do_reset();
      joystick_down = 1'b1;
      run(30);
      update_screen = 1'b1;
      arcade_button_pressed = 1'b1;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      update_screen = 1'b0;
      joystick_down = 1'b0;
      arcade_button_pressed = 1'b0;
      check_count++; if (ball_top !== 10'd236 || ball_left !== 10'd316)
         $display("FAIL midreset_ball: got (%0d,%0d) expected (236,316)", ball_top, ball_left); else pass_count++;
      check_count++; if (paddleY !== 10'd208) $display("FAIL midreset_paddleY: got %0d expected 208", paddleY); else pass_count++;
      run(1);
      check_count++; if (ball_top !== 10'd238 || ball_left !== 10'd318)
         $display("FAIL midreset_resume: got (%0d,%0d) expected (238,318)", ball_top, ball_left); else pass_count++;
      $display("test_reset_mid_play: top=%0d left=%0d py=%0d", ball_top, ball_left, paddleY);
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_wall_bounce();
      test_paddle();
      test_paddle_hit();
      test_serve();
      test_reset_mid_play();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
